// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: counting payload, tlast/tuser_mty on the final beat,
// optional inter-packet gap, stop/abort control and throughput counters.
module axis_pkt_gen #(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_MTY_WIDTH  = 8,
    parameter int C_LEN_BITS   = 16,
    parameter int C_GAP_BITS   = 8
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic                    cfg_abort,
    input  logic [C_LEN_BITS-1:0]   cfg_pkt_beats,
    input  logic [C_LEN_BITS-1:0]   cfg_pkt_count,
    input  logic [C_GAP_BITS-1:0]   cfg_gap_cycles,
    input  logic [C_MTY_WIDTH-1:0]  cfg_last_mty,
    output logic                    m_axis_tvalid,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [C_MTY_WIDTH-1:0]  m_axis_tuser_mty,
    input  logic                    m_axis_tready,
    output logic                    drop_incmpt_pkt,
    output logic                    busy,
    output logic [31:0]             pkts_sent,
    output logic [31:0]             beats_sent
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                  state, state_n;
    logic [C_LEN_BITS-1:0]   len_q, cnt_q, beat, beat_n, run_pkts, run_pkts_n, len_n;
    logic [C_GAP_BITS-1:0]   gap_q, gap_cnt, gap_cnt_n;
    logic [C_MTY_WIDTH-1:0]  mty_q, mty_sel;
    logic [C_DATA_WIDTH-1:0] seq_n;
    logic                    abort_pend, stop_pend;
    logic                    tvalid_n, tlast_n, drop_n;

    wire accept    = m_axis_tvalid && m_axis_tready;
    wire is_last   = (beat == len_q - C_LEN_BITS'(1));
    wire abort_now = abort_pend || cfg_abort;
    wire stop_now  = stop_pend || cfg_stop;
    wire run_done  = (cnt_q != '0) && (run_pkts + C_LEN_BITS'(1) == cnt_q);
    wire pkt_end   = accept && (is_last || abort_now);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state            <= IDLE;
            len_q            <= C_LEN_BITS'(1);
            cnt_q            <= '0;
            gap_q            <= '0;
            mty_q            <= '0;
            beat             <= '0;
            run_pkts         <= '0;
            gap_cnt          <= '0;
            abort_pend       <= 1'b0;
            stop_pend        <= 1'b0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tdata     <= '0;
            m_axis_tlast     <= 1'b0;
            m_axis_tuser_mty <= '0;
            drop_incmpt_pkt  <= 1'b0;
            busy             <= 1'b0;
            pkts_sent        <= '0;
            beats_sent       <= '0;
        end else begin
            state    <= state_n;
            beat     <= beat_n;
            run_pkts <= run_pkts_n;
            gap_cnt  <= gap_cnt_n;
            if (state == IDLE && cfg_start) begin
                len_q <= len_n;
                cnt_q <= cfg_pkt_count;
                gap_q <= cfg_gap_cycles;
                mty_q <= cfg_last_mty;
            end
            // Abort arms only in SEND and is consumed by the next accepted beat.
            if (state != SEND || accept) abort_pend <= 1'b0;
            else if (cfg_abort)          abort_pend <= 1'b1;
            if (state == IDLE || state_n == IDLE) stop_pend <= 1'b0;
            else if (cfg_stop)                    stop_pend <= 1'b1;
            m_axis_tvalid    <= tvalid_n;
            m_axis_tdata     <= seq_n;
            m_axis_tlast     <= tlast_n;
            m_axis_tuser_mty <= tlast_n ? mty_sel : '0;
            drop_incmpt_pkt  <= drop_n;
            busy             <= (state_n != IDLE);
            if (accept)            beats_sent <= beats_sent + 32'd1;
            if (accept && is_last) pkts_sent  <= pkts_sent + 32'd1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (cfg_start) state_n = SEND;
            SEND: if (pkt_end) begin
                if ((is_last && run_done) || stop_now) state_n = IDLE;
                else if (gap_q == '0)                  state_n = SEND;
                else                                   state_n = GAP;
            end
            GAP: begin
                if (stop_now)               state_n = IDLE;
                else if (gap_cnt == gap_q)  state_n = SEND;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        beat_n     = beat;
        run_pkts_n = run_pkts;
        gap_cnt_n  = gap_cnt;
        seq_n      = m_axis_tdata;
        drop_n     = 1'b0;
        len_n      = len_q;
        mty_sel    = mty_q;
        case (state)
            IDLE: if (cfg_start) begin
                len_n      = (cfg_pkt_beats == '0) ? C_LEN_BITS'(1) : cfg_pkt_beats;
                mty_sel    = cfg_last_mty;
                beat_n     = '0;
                run_pkts_n = '0;
            end
            SEND: if (accept) begin
                seq_n = m_axis_tdata + C_DATA_WIDTH'(1);
                if (is_last) begin
                    beat_n     = '0;
                    run_pkts_n = run_pkts + C_LEN_BITS'(1);
                end else if (abort_now) begin
                    beat_n = '0;
                    drop_n = 1'b1;
                end else begin
                    beat_n = beat + C_LEN_BITS'(1);
                end
            end
            GAP: gap_cnt_n = gap_cnt + C_GAP_BITS'(1);
            default: ;
        endcase
        if (state == SEND && state_n == GAP) gap_cnt_n = C_GAP_BITS'(1);
        // The drop cycle always shows tvalid=0, even when the next packet follows with no gap.
        tvalid_n = (state_n == SEND) && !drop_n;
        tlast_n  = tvalid_n && (beat_n == len_n - C_LEN_BITS'(1));
    end
endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: table of run configurations checked beat by beat,
// plus hand sequences for backpressure, abort, stop and reset.
module tb_axis_pkt_gen;
    logic        aclk = 1'b0, areset = 1'b1;
    logic        cfg_start = 0, cfg_stop = 0, cfg_abort = 0;
    logic [15:0] cfg_pkt_beats = 0, cfg_pkt_count = 0;
    logic [7:0]  cfg_gap_cycles = 0, cfg_last_mty = 0;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
    logic [7:0]  m_axis_tdata, m_axis_tuser_mty;
    logic        drop_incmpt_pkt, busy;
    logic [31:0] pkts_sent, beats_sent;

    axis_pkt_gen dut (
        .aclk(aclk), .areset(areset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_abort(cfg_abort), .cfg_pkt_beats(cfg_pkt_beats), .cfg_pkt_count(cfg_pkt_count),
        .cfg_gap_cycles(cfg_gap_cycles), .cfg_last_mty(cfg_last_mty),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser_mty(m_axis_tuser_mty), .m_axis_tready(m_axis_tready),
        .drop_incmpt_pkt(drop_incmpt_pkt), .busy(busy), .pkts_sent(pkts_sent),
        .beats_sent(beats_sent)
    );

    always #5 aclk = ~aclk;

    int total = 0, bad = 0;
    logic [7:0] exp_seq = 8'd0;

    typedef struct {
        int beats; int count; int gap; int mty;
        int exp_beats; int exp_pkts;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge where the first beat is visible.
    task automatic start(input int beats, input int count, input int gap, input int mty);
        cfg_pkt_beats  = 16'(beats);
        cfg_pkt_count  = 16'(count);
        cfg_gap_cycles = 8'(gap);
        cfg_last_mty   = 8'(mty);
        cfg_start      = 1'b1;
        @(negedge aclk);
        cfg_start = 1'b0;
    endtask

    initial begin
        logic [31:0] p0, b0;
        logic [7:0]  hold_d;
        logic        hold_l, stall;
        int L, b, nb, np, idle, cyc, acc;
        bit seen_last;
        int pat[6];

        tbl[0] = '{4, 2, 0, 3, 8, 2};   // back-to-back, mty on beats 3 and 7
        tbl[1] = '{2, 3, 5, 0, 6, 3};   // 5-cycle gaps
        tbl[2] = '{0, 3, 0, 7, 3, 3};   // zero length -> every beat is last
        tbl[3] = '{1, 2, 2, 1, 2, 2};
        pat = '{1, 0, 0, 1, 0, 1};

        repeat (3) @(negedge aclk);
        areset = 1'b0;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkts", pkts_sent, 0);
        chk("rst_beats", beats_sent, 0);

        for (int v = 0; v < 4; v++) begin
            p0 = pkts_sent; b0 = beats_sent;
            start(tbl[v].beats, tbl[v].count, tbl[v].gap, tbl[v].mty);
            L = (tbl[v].beats == 0) ? 1 : tbl[v].beats;
            b = 0; nb = 0; np = 0; idle = 0; cyc = 0; seen_last = 0;
            while (busy && cyc < 500) begin
                if (m_axis_tvalid) begin
                    if (seen_last) begin
                        chk("gap_len", idle, tbl[v].gap);
                        seen_last = 0;
                    end
                    chk("tdata", m_axis_tdata, exp_seq);
                    chk("tlast", m_axis_tlast, (b == L - 1));
                    chk("mty", m_axis_tuser_mty, (b == L - 1) ? tbl[v].mty : 0);
                    exp_seq++; nb++;
                    if (b == L - 1) begin b = 0; np++; seen_last = 1; idle = 0; end
                    else b++;
                end else idle++;
                @(negedge aclk); cyc++;
            end
            chk("run_timeout", (cyc < 500), 1);
            chk("no_gap_after_last", idle, 0);
            chk("end_tvalid", m_axis_tvalid, 0);
            chk("run_beats", nb, tbl[v].exp_beats);
            chk("run_pkts", np, tbl[v].exp_pkts);
            chk("pkts_sent", pkts_sent - p0, tbl[v].exp_pkts);
            chk("beats_sent", beats_sent - b0, tbl[v].exp_beats);
        end

        // Backpressure: payload and tlast hold while stalled.
        b0 = beats_sent;
        start(3, 1, 0, 0);
        acc = 0; stall = 0; hold_d = 0; hold_l = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            if (stall) begin
                chk("stall_tvalid", m_axis_tvalid, 1);
                chk("stall_tdata", m_axis_tdata, hold_d);
                chk("stall_tlast", m_axis_tlast, hold_l);
            end
            m_axis_tready = (i < 6) ? pat[i][0] : 1'b1;
            stall = 0;
            if (m_axis_tvalid && m_axis_tready) begin
                chk("bp_tdata", m_axis_tdata, exp_seq);
                chk("bp_tlast", m_axis_tlast, (acc == 2));
                exp_seq++; acc++;
            end else if (m_axis_tvalid) begin
                stall = 1; hold_d = m_axis_tdata; hold_l = m_axis_tlast;
            end
            @(negedge aclk);
        end
        m_axis_tready = 1'b1;
        chk("bp_accepts", acc, 3);
        chk("bp_beats_sent", beats_sent - b0, 3);
        chk("bp_idle", busy, 0);

        // Abort during beat 2 of 8, unlimited run, then stop mid-packet.
        p0 = pkts_sent;
        start(8, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("ab_tdata", m_axis_tdata, exp_seq);
            chk("ab_no_tlast", m_axis_tlast, 0);
            if (i == 2) cfg_abort = 1'b1;
            exp_seq++;
            @(negedge aclk);
            cfg_abort = 1'b0;
        end
        chk("ab_drop", drop_incmpt_pkt, 1);
        chk("ab_tvalid", m_axis_tvalid, 0);
        chk("ab_pkts", pkts_sent - p0, 0);
        @(negedge aclk);
        chk("ab_drop_1cyc", drop_incmpt_pkt, 0);
        for (int i = 0; i < 8; i++) begin
            chk("ab2_tvalid", m_axis_tvalid, 1);
            chk("ab2_tdata", m_axis_tdata, exp_seq);
            chk("ab2_tlast", m_axis_tlast, (i == 7));
            if (i == 3) cfg_stop = 1'b1;
            exp_seq++;
            @(negedge aclk);
            cfg_stop = 1'b0;
        end
        chk("stop_idle", busy, 0);
        chk("stop_tvalid", m_axis_tvalid, 0);
        chk("ab2_pkts", pkts_sent - p0, 1);

        // Abort on the last beat is discarded.
        p0 = pkts_sent;
        start(2, 1, 0, 5);
        chk("abl_b0", m_axis_tlast, 0);
        exp_seq++;
        @(negedge aclk);
        chk("abl_b1_last", m_axis_tlast, 1);
        chk("abl_b1_mty", m_axis_tuser_mty, 5);
        cfg_abort = 1'b1;
        exp_seq++;
        @(negedge aclk);
        cfg_abort = 1'b0;
        chk("abl_no_drop", drop_incmpt_pkt, 0);
        chk("abl_pkts", pkts_sent - p0, 1);
        chk("abl_idle", busy, 0);

        // Reset during beat 3 of 6.
        start(6, 1, 0, 0);
        repeat (3) @(negedge aclk);
        chk("rs_beat3", m_axis_tdata, exp_seq + 8'd3);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        chk("rs_tvalid", m_axis_tvalid, 0);
        chk("rs_drop", drop_incmpt_pkt, 0);
        chk("rs_tdata", m_axis_tdata, 0);
        chk("rs_busy", busy, 0);
        chk("rs_pkts", pkts_sent, 0);
        chk("rs_beats", beats_sent, 0);
        start(1, 1, 0, 2);
        chk("rs2_tvalid", m_axis_tvalid, 1);
        chk("rs2_tdata", m_axis_tdata, 0);
        chk("rs2_tlast", m_axis_tlast, 1);
        chk("rs2_mty", m_axis_tuser_mty, 2);
        @(negedge aclk);
        chk("rs2_idle", busy, 0);
        chk("rs2_pkts", pkts_sent, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
